sensor_on_isleyici: RTL and testbench

Front-end conditioning stage that sits directly upstream of the flight autopilot FSM. It low-pass filters the raw GNSS and altimeter altitude samples and flags stale sensors, substituting the healthy sensor for a stale one. It also debounces the operator's target-altitude entry into a single-cycle "altitude info valid" strobe. Its outputs map one-to-one onto the autopilot's `gnss`, `altimetre`, `hedef_yukseklik` and `yukseklik_bilgisi` inputs.

---
 rtl/sensor_on_isleyici.sv | 193 +++++++++++++++++++
 tb/tb_sensor_on_isleyici.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/sensor_on_isleyici.sv
// Sensor conditioning ahead of the autopilot: moving-average filters, stale
// detection with cross-substitution, and a debounced target-altitude strobe.
//
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   gnss_raw_i/gnss_valid_i  raw GNSS altitude and one-cycle qualifier
//   alt_raw_i/alt_valid_i    raw altimeter altitude and one-cycle qualifier
//   hedef_i/hedef_valid_i    operator target altitude and held "enter"
//   gnss_o, altimetre_o      filtered (or substituted) altitudes
//   hedef_yukseklik_o        last accepted target altitude
//   yukseklik_bilgisi_o      one-cycle pulse per accepted entry
//   sensor_hata_o            {altimeter stale, GNSS stale}

module soi_ortalama #(
    parameter int unsigned TIMEOUT = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] raw_i,
    input  logic       valid_i,
    output logic [5:0] avg_o,
    output logic       stale_o
);

    logic [5:0]  win_q [4];
    logic [5:0]  win_d [4];
    logic [7:0]  sum_q, sum_d;
    logic [1:0]  idx_q, idx_d;
    logic [15:0] cnt_q, cnt_d;
    logic        seen_q, seen_d;

    always_comb begin
        win_d  = win_q;
        sum_d  = sum_q;
        idx_d  = idx_q;
        seen_d = seen_q;
        cnt_d  = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
        if (valid_i) begin
            cnt_d  = '0;
            seen_d = 1'b1;
            if (!seen_q) begin
                // First sample fills the window so the average starts on it.
                for (int i = 0; i < 4; i++) begin
                    win_d[i] = raw_i;
                end
                sum_d = {raw_i, 2'b00};
                idx_d = '0;
            end else begin
                sum_d        = sum_q + {2'b00, raw_i} - {2'b00, win_q[idx_q]};
                win_d[idx_q] = raw_i;
                idx_d        = idx_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                win_q[i] <= '0;
            end
            sum_q  <= '0;
            idx_q  <= '0;
            cnt_q  <= '0;
            seen_q <= 1'b0;
        end else begin
            win_q  <= win_d;
            sum_q  <= sum_d;
            idx_q  <= idx_d;
            cnt_q  <= cnt_d;
            seen_q <= seen_d;
        end
    end

    assign avg_o   = sum_q[7:2];
    assign stale_o = !seen_q || (cnt_q >= 16'(TIMEOUT));

endmodule

module sensor_on_isleyici #(
    parameter int unsigned TIMEOUT  = 1000,
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] gnss_raw_i,
    input  logic       gnss_valid_i,
    input  logic [5:0] alt_raw_i,
    input  logic       alt_valid_i,
    input  logic [5:0] hedef_i,
    input  logic       hedef_valid_i,
    output logic [5:0] gnss_o,
    output logic [5:0] altimetre_o,
    output logic [5:0] hedef_yukseklik_o,
    output logic       yukseklik_bilgisi_o,
    output logic [1:0] sensor_hata_o
);

    typedef enum logic [1:0] {
        IDLE,
        DEB,
        WREL
    } durum_e;

    logic [5:0] gnss_avg, alt_avg;
    logic       gnss_stale, alt_stale;

    soi_ortalama #(.TIMEOUT(TIMEOUT)) u_gnss (
        .clk     (clk),
        .rst     (rst),
        .raw_i   (gnss_raw_i),
        .valid_i (gnss_valid_i),
        .avg_o   (gnss_avg),
        .stale_o (gnss_stale)
    );

    soi_ortalama #(.TIMEOUT(TIMEOUT)) u_alt (
        .clk     (clk),
        .rst     (rst),
        .raw_i   (alt_raw_i),
        .valid_i (alt_valid_i),
        .avg_o   (alt_avg),
        .stale_o (alt_stale)
    );

    // A stale sensor borrows the healthy one; otherwise each keeps its own.
    assign gnss_o      = (gnss_stale && !alt_stale) ? alt_avg : gnss_avg;
    assign altimetre_o = (alt_stale && !gnss_stale) ? gnss_avg : alt_avg;
    assign sensor_hata_o = {alt_stale, gnss_stale};

    durum_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [5:0] cap_q, cap_d;
    logic [5:0] hedef_q, hedef_d;
    logic       puls_q, puls_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cap_d   = cap_q;
        hedef_d = hedef_q;
        puls_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (hedef_valid_i) begin
                    state_d = DEB;
                    cap_d   = hedef_i;
                    cnt_d   = 8'd1;
                end
            end
            DEB: begin
                if (!hedef_valid_i) begin
                    state_d = IDLE;
                end else if (hedef_i != cap_q) begin
                    cap_d = hedef_i;
                    cnt_d = 8'd1;
                end else if (cnt_q + 8'd1 == 8'(DEBOUNCE)) begin
                    cnt_d   = cnt_q + 8'd1;
                    hedef_d = cap_q;
                    puls_d  = 1'b1;
                    state_d = WREL;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            WREL: begin
                if (!hedef_valid_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cap_q   <= '0;
            hedef_q <= '0;
            puls_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cap_q   <= cap_d;
            hedef_q <= hedef_d;
            puls_q  <= puls_d;
        end
    end

    assign hedef_yukseklik_o   = hedef_q;
    assign yukseklik_bilgisi_o = puls_q;

endmodule

// File: tb/tb_sensor_on_isleyici.sv
// Directed bench for sensor_on_isleyici with TIMEOUT=8, DEBOUNCE=4.
// Inputs change 1ns after a rising edge; outputs are checked there too.

module tb_sensor_on_isleyici;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [5:0] gnss_raw_i = '0;
    logic       gnss_valid_i = 1'b0;
    logic [5:0] alt_raw_i = '0;
    logic       alt_valid_i = 1'b0;
    logic [5:0] hedef_i = '0;
    logic       hedef_valid_i = 1'b0;
    logic [5:0] gnss_o, altimetre_o, hedef_yukseklik_o;
    logic       yukseklik_bilgisi_o;
    logic [1:0] sensor_hata_o;

    int errs = 0;
    int checks = 0;
    int npuls;
    int first;

    sensor_on_isleyici #(.TIMEOUT(8), .DEBOUNCE(4)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .gnss_raw_i          (gnss_raw_i),
        .gnss_valid_i        (gnss_valid_i),
        .alt_raw_i           (alt_raw_i),
        .alt_valid_i         (alt_valid_i),
        .hedef_i             (hedef_i),
        .hedef_valid_i       (hedef_valid_i),
        .gnss_o              (gnss_o),
        .altimetre_o         (altimetre_o),
        .hedef_yukseklik_o   (hedef_yukseklik_o),
        .yukseklik_bilgisi_o (yukseklik_bilgisi_o),
        .sensor_hata_o       (sensor_hata_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic both(input logic [5:0] g, input logic gv,
                        input logic [5:0] a, input logic av);
        gnss_raw_i = g;
        gnss_valid_i = gv;
        alt_raw_i = a;
        alt_valid_i = av;
        tick();
        gnss_valid_i = 1'b0;
        alt_valid_i = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        chk("rst_gnss", gnss_o, 0);
        chk("rst_alt", altimetre_o, 0);
        chk("rst_hata", sensor_hata_o, 2'b11);
        chk("rst_hedef", hedef_yukseklik_o, 0);
        chk("rst_puls", yukseklik_bilgisi_o, 0);
        rst = 1'b1;

        // Preload on first sample; healthy GNSS covers stale altimeter.
        both(6'd40, 1'b1, 6'd0, 1'b0);
        chk("pre_gnss", gnss_o, 40);
        chk("pre_hata", sensor_hata_o, 2'b10);
        chk("pre_subalt", altimetre_o, 40);
        both(6'd0, 1'b0, 6'd36, 1'b1);
        chk("pre_alt", altimetre_o, 36);
        chk("pre_hata2", sensor_hata_o, 2'b00);

        // Window 40x4: 44->164/4=41, 48->172->43, 52->184->46, 56->200->50
        both(6'd44, 1'b1, 6'd36, 1'b1);
        chk("avg44", gnss_o, 41);
        both(6'd48, 1'b1, 6'd36, 1'b1);
        chk("avg48", gnss_o, 43);
        both(6'd52, 1'b1, 6'd36, 1'b1);
        chk("avg52", gnss_o, 46);
        both(6'd56, 1'b1, 6'd36, 1'b1);
        chk("avg56", gnss_o, 50);
        chk("alt_hold", altimetre_o, 36);
        for (int i = 0; i < 4; i++) both(6'd63, 1'b1, 6'd36, 1'b1);
        chk("avg63", gnss_o, 63);

        // Altimeter settles at 30, GNSS at 50.
        for (int i = 0; i < 4; i++) both(6'd50, 1'b1, 6'd30, 1'b1);
        chk("alt30", altimetre_o, 30);
        chk("gnss50", gnss_o, 50);
        for (int i = 0; i < 7; i++) both(6'd50, 1'b1, 6'd0, 1'b0);
        chk("to7_hata", sensor_hata_o, 2'b00);
        chk("to7_alt", altimetre_o, 30);
        both(6'd50, 1'b1, 6'd0, 1'b0);
        chk("to8_hata", sensor_hata_o, 2'b10);
        chk("to8_sub", altimetre_o, 50);
        both(6'd50, 1'b1, 6'd30, 1'b1);
        chk("rec_hata", sensor_hata_o, 2'b00);
        chk("rec_alt", altimetre_o, 30);

        // Valid arriving on the timeout edge keeps the flag low.
        for (int i = 0; i < 7; i++) both(6'd50, 1'b1, 6'd0, 1'b0);
        both(6'd50, 1'b1, 6'd30, 1'b1);
        chk("race_hata", sensor_hata_o, 2'b00);

        // GNSS goes stale, borrows altimeter; then both stale hold own.
        for (int i = 0; i < 8; i++) both(6'd0, 1'b0, 6'd30, 1'b1);
        chk("gto_hata", sensor_hata_o, 2'b01);
        chk("gto_sub", gnss_o, 30);
        for (int i = 0; i < 8; i++) both(6'd0, 1'b0, 6'd0, 1'b0);
        chk("both_hata", sensor_hata_o, 2'b11);
        chk("both_gnss", gnss_o, 50);
        chk("both_alt", altimetre_o, 30);

        // Long press: one pulse at the 4th sampled edge.
        hedef_i = 6'd25;
        hedef_valid_i = 1'b1;
        npuls = 0;
        first = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (yukseklik_bilgisi_o) begin
                npuls++;
                if (first == 0) first = i;
            end
        end
        chk("long_npuls", npuls, 1);
        chk("long_first", first, 4);
        chk("long_hedef", hedef_yukseklik_o, 25);
        hedef_valid_i = 1'b0;
        tick();
        tick();

        // Bounce: 2-cycle press, release, real press.
        hedef_i = 6'd10;
        npuls = 0;
        first = 0;
        for (int i = 1; i <= 8; i++) begin
            hedef_valid_i = (i != 3);
            tick();
            if (yukseklik_bilgisi_o) begin
                npuls++;
                if (first == 0) first = i;
            end
        end
        chk("bnc_npuls", npuls, 1);
        chk("bnc_first", first, 7);
        chk("bnc_hedef", hedef_yukseklik_o, 10);
        hedef_valid_i = 1'b0;
        tick();
        tick();

        // Value change restarts the count.
        npuls = 0;
        first = 0;
        hedef_valid_i = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            hedef_i = (i < 3) ? 6'd20 : 6'd21;
            tick();
            if (yukseklik_bilgisi_o) begin
                npuls++;
                if (first == 0) first = i;
            end
        end
        chk("chg_npuls", npuls, 1);
        chk("chg_first", first, 6);
        chk("chg_hedef", hedef_yukseklik_o, 21);
        hedef_valid_i = 1'b0;
        tick();

        // Reset with cnt=3 in DEB.
        hedef_i = 6'd33;
        hedef_valid_i = 1'b1;
        tick();
        tick();
        tick();
        rst = 1'b0;
        hedef_valid_i = 1'b0;
        tick();
        chk("mrst_puls", yukseklik_bilgisi_o, 0);
        chk("mrst_hedef", hedef_yukseklik_o, 0);
        chk("mrst_hata", sensor_hata_o, 2'b11);
        chk("mrst_gnss", gnss_o, 0);
        rst = 1'b1;
        npuls = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (yukseklik_bilgisi_o) npuls++;
        end
        chk("mrst_nopuls", npuls, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
